// File: rtl/series_pkg.sv
// Shared types and defaults for the series trend monitor.
// Holds the FSM state codes, per-cycle flag classes and the classifier.
package series_pkg;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_RISING  = 2'd1,
    S_FALLING = 2'd2,
    S_FAULT   = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    C_HOLD    = 2'd0,
    C_STEP_UP = 2'd1,
    C_STEP_DN = 2'd2,
    C_ERR     = 2'd3
  } flag_class_e;

  localparam int unsigned RUN_LEN_DEF   = 4;
  localparam int unsigned ERR_LIMIT_DEF = 3;

  // Any jump flag, or more than one flag at once, is an error cycle.
  function automatic flag_class_e classify(
    input logic incr,
    input logic decr,
    input logic error
  );
    flag_class_e c;
    unique case ({error, incr, decr})
      3'b000:  c = C_HOLD;
      3'b010:  c = C_STEP_UP;
      3'b001:  c = C_STEP_DN;
      default: c = C_ERR;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear (clear wins over inc).
// Asynchronous active-high reset.
module sat_counter #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] count
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (inc && (count_q != {W{1'b1}})) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/series_trend_monitor.sv
// Tracks rising/falling runs of step flags and latches a sticky
// fault after ERR_LIMIT consecutive error cycles.
module series_trend_monitor
  import series_pkg::*;
#(
  parameter int unsigned RUN_LEN   = RUN_LEN_DEF,
  parameter int unsigned ERR_LIMIT = ERR_LIMIT_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       incr,
  input  logic       decr,
  input  logic       error,
  input  logic       clear,
  output logic       trend_up,
  output logic       trend_down,
  output logic       fault,
  output logic [7:0] err_total,
  output logic [1:0] state
);

  localparam logic [3:0] RUN_MAX = 4'(RUN_LEN);
  localparam logic [4:0] ERR_MAX = 5'(ERR_LIMIT);

  state_e      state_q, state_d;
  logic [3:0]  run_cnt_q, run_cnt_d;
  logic        trend_up_q, trend_up_d;
  logic        trend_down_q, trend_down_d;
  logic [3:0]  consec_err;
  flag_class_e cls;
  logic        is_err, is_step, fault_hit;

  assign cls     = classify(incr, decr, error);
  assign is_err  = (cls == C_ERR);
  assign is_step = (cls == C_STEP_UP) || (cls == C_STEP_DN);

  // The counter updates this edge too, so compare against its next value.
  assign fault_hit = is_err && (({1'b0, consec_err} + 5'd1) >= ERR_MAX);

  sat_counter #(.W(4)) u_consec_err (
    .clk   (clk),
    .rst   (reset),
    .inc   (is_err),
    .clr   (clear || is_step),
    .count (consec_err)
  );

  sat_counter #(.W(8)) u_err_total (
    .clk   (clk),
    .rst   (reset),
    .inc   (is_err),
    .clr   (clear),
    .count (err_total)
  );

  always_comb begin
    state_d   = state_q;
    run_cnt_d = run_cnt_q;
    if (clear) begin
      state_d   = S_IDLE;
      run_cnt_d = '0;
    end else if (fault_hit) begin
      state_d   = S_FAULT;
      run_cnt_d = '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (cls == C_STEP_UP) begin
            state_d   = S_RISING;
            run_cnt_d = 4'd1;
          end else if (cls == C_STEP_DN) begin
            state_d   = S_FALLING;
            run_cnt_d = 4'd1;
          end
        end
        S_RISING: begin
          if (cls == C_STEP_UP) begin
            if (run_cnt_q < RUN_MAX) run_cnt_d = run_cnt_q + 4'd1;
          end else if (cls == C_STEP_DN) begin
            state_d   = S_FALLING;
            run_cnt_d = 4'd1;
          end else if (cls == C_ERR) begin
            state_d   = S_IDLE;
            run_cnt_d = '0;
          end
        end
        S_FALLING: begin
          if (cls == C_STEP_DN) begin
            if (run_cnt_q < RUN_MAX) run_cnt_d = run_cnt_q + 4'd1;
          end else if (cls == C_STEP_UP) begin
            state_d   = S_RISING;
            run_cnt_d = 4'd1;
          end else if (cls == C_ERR) begin
            state_d   = S_IDLE;
            run_cnt_d = '0;
          end
        end
        default: begin
          state_d   = S_FAULT;
          run_cnt_d = '0;
        end
      endcase
    end
    trend_up_d   = (state_d == S_RISING)  && (run_cnt_d == RUN_MAX);
    trend_down_d = (state_d == S_FALLING) && (run_cnt_d == RUN_MAX);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      run_cnt_q    <= '0;
      trend_up_q   <= 1'b0;
      trend_down_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      run_cnt_q    <= run_cnt_d;
      trend_up_q   <= trend_up_d;
      trend_down_q <= trend_down_d;
    end
  end

  assign trend_up   = trend_up_q;
  assign trend_down = trend_down_q;
  assign fault      = (state_q == S_FAULT);
  assign state      = state_q;

endmodule

// File: doc/series_trend_monitor.md
SERIES_TREND_MONITOR -- requirements
Module: series_trend_monitor

Interface
REQ-001 SHALL have parameter RUN_LEN, default 4, consecutive same-direction steps that declare a trend (legal 2..15).
REQ-002 SHALL have parameter ERR_LIMIT, default 3, consecutive error cycles that declare a fault (legal 1..15).
REQ-003 SHALL have port clk  input  1  single clock, all logic on posedge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port incr  input  1  step-up flag from the upstream series detector.
REQ-006 SHALL have port decr  input  1  step-down flag from the upstream series detector.
REQ-007 SHALL have port error  input  1  jump flag from the upstream series detector.
REQ-008 SHALL have port clear  input  1  synchronous fault acknowledge and counter clear.
REQ-009 SHALL have port trend_up  output  1  registered; rising run of RUN_LEN reached.
REQ-010 SHALL have port trend_down  output  1  registered; falling run of RUN_LEN reached.
REQ-011 SHALL have port fault  output  1  registered, sticky until clear.
REQ-012 SHALL have port err_total  output  8  registered saturating count of all error cycles.
REQ-013 SHALL have port state  output  2  registered current FSM state code.

Function
REQ-014 SHALL classify each cycle: STEP_UP = incr only; STEP_DN = decr only; ERR = error, or any two or more flags high; HOLD = no flag.
REQ-015 SHALL implement FSM states IDLE=0, RISING=1, FALLING=2, FAULT=3.
REQ-016 IDLE: STEP_UP -> RISING, run_cnt=1; STEP_DN -> FALLING, run_cnt=1; HOLD or ERR -> stay IDLE.
REQ-017 RISING: STEP_UP -> run_cnt+1, saturating at RUN_LEN; STEP_DN -> FALLING, run_cnt=1; HOLD -> no change; ERR -> IDLE, run_cnt=0.
REQ-018 FALLING: mirror of RISING with STEP_UP and STEP_DN swapped.
REQ-019 SHALL keep a 4-bit consec_err count: +1 on ERR, cleared on STEP_UP or STEP_DN, held on HOLD.
REQ-020 When an ERR cycle makes consec_err equal ERR_LIMIT, next state SHALL be FAULT regardless of the current state.
REQ-021 FAULT: ignore incr/decr; hold run_cnt at 0; err_total keeps counting ERR cycles; exit only on clear.
REQ-022 err_total SHALL increment on every ERR cycle in any state and saturate at 255 with no wrap.
REQ-023 trend_up SHALL equal (next state == RISING and next run_cnt == RUN_LEN), so it is high the cycle after the completing flag; trend_down mirrors this for FALLING.
REQ-024 fault SHALL be high exactly while state == FAULT.
REQ-025 clear SHALL take priority over all flags in the same cycle: next state IDLE; run_cnt, consec_err and err_total zero; that cycle's flags discarded.
REQ-026 HOLD cycles SHALL neither break nor extend a run.

Reset
REQ-027 Asserting reset SHALL immediately force state=IDLE, all outputs and internal counters to 0, independent of clk.
REQ-028 Operation SHALL resume on the first posedge clk after reset deasserts; reset mid-run or mid-fault SHALL discard all history.

Structure
REQ-029 Shared package series_pkg SHALL hold the state enum typedef, the flag-class typedef and the default RUN_LEN/ERR_LIMIT constants.
REQ-030 Submodule sat_counter (parameterized width, inc/clr inputs, saturating) SHALL be used for err_total and consec_err.

Verification
REQ-031 incr pulses 4 consecutive cycles from reset -> trend_up=1 one cycle after the 4th, state=1, trend_down=0.
REQ-032 incr x3, idle x2, incr x1 -> trend_up=1 after the 4th incr; the idle cycles do not break the run.
REQ-033 incr x4 then decr x1 -> trend_up=0, state=2, trend_down=0 next cycle; decr x3 more -> trend_down=1.
REQ-034 error x3 -> fault=1 and state=3 after the 3rd, err_total=3; incr x5 -> fault stays 1, err_total=3; clear -> state=0, fault=0, err_total=0 next cycle.
REQ-035 incr and decr high together x3 -> treated as ERR, fault=1; error held 300 cycles -> err_total=255.
REQ-036 reset pulsed between clk edges during RISING with run_cnt=3 -> all outputs 0 at once; incr x3 afterwards -> trend_up stays 0.
